// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR3 command FIFO write port between two hosts,
// with tREFI-driven refresh insertion. Define ARB_STATS_EN to add grant counters.
module ddr3_cmd_arbiter #(
  parameter int unsigned T_REFI     = 1560,
  parameter int unsigned REF_URGENT = 4,
  parameter int unsigned REF_MAX    = 8,
  parameter logic [2:0]  REF_OPC    = 3'b011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        req0_valid,
  input  logic [33:0] req0_cmd,
  output logic        req0_ack,
  input  logic        req1_valid,
  input  logic [33:0] req1_cmd,
  output logic        req1_ack,
  input  logic        CMD_full,
  output logic        CMD_put,
  output logic [33:0] CMD_data_in,
  output logic [3:0]  ref_pending,
`ifdef ARB_STATS_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [15:0] ref_cnt,
`endif
  output logic        ref_overflow
);

  localparam int unsigned TW = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam logic [TW-1:0] RELOAD   = TW'(T_REFI - 1);
  localparam logic [3:0]    P_MAX    = 4'(REF_MAX);
  localparam logic [3:0]    P_URGENT = 4'(REF_URGENT);
  localparam logic [33:0]   REF_WORD = {REF_OPC, 31'b0};

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_P0, SRC_P1, SRC_REF} src_t;

  state_t        state, next_state;
  src_t          src_q, src_d;
  logic [33:0]   data_q, data_d;
  logic          rr_last;
  logic [TW-1:0] timer;
  logic          expire, ref_issue;

  assign expire    = ready && (timer == '0);
  assign ref_issue = (state == ISSUE) && (src_q == SRC_REF);

  assign CMD_put     = (state == ISSUE);
  assign CMD_data_in = data_q;
  assign req0_ack    = (state == ISSUE) && (src_q == SRC_P0);
  assign req1_ack    = (state == ISSUE) && (src_q == SRC_P1);

  always_comb begin
    next_state = state;
    src_d      = src_q;
    data_d     = data_q;
    case (state)
      IDLE: begin
        if (ready && !CMD_full) begin
          // urgent refresh > round-robin hosts > opportunistic refresh
          if (ref_pending >= P_URGENT)             src_d = SRC_REF;
          else if (req0_valid && req1_valid)       src_d = rr_last ? SRC_P0 : SRC_P1;
          else if (req0_valid)                     src_d = SRC_P0;
          else if (req1_valid)                     src_d = SRC_P1;
          else if (ref_pending != '0)              src_d = SRC_REF;
          else                                     src_d = SRC_NONE;
          case (src_d)
            SRC_P0:  data_d = req0_cmd;
            SRC_P1:  data_d = req1_cmd;
            SRC_REF: data_d = REF_WORD;
            default: data_d = data_q;
          endcase
          if (src_d != SRC_NONE) next_state = ISSUE;
        end
      end
      ISSUE:   next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      src_q        <= SRC_NONE;
      data_q       <= '0;
      rr_last      <= 1'b1;
      timer        <= RELOAD;
      ref_pending  <= '0;
      ref_overflow <= 1'b0;
    end else begin
      state  <= next_state;
      src_q  <= src_d;
      data_q <= data_d;
      if (state == ISSUE && src_q == SRC_P0) rr_last <= 1'b0;
      if (state == ISSUE && src_q == SRC_P1) rr_last <= 1'b1;
      if (ready) timer <= (timer == '0) ? RELOAD : timer - 1'b1;
      if (expire && ref_pending == P_MAX) ref_overflow <= 1'b1;
      // simultaneous expiry and refresh issue leave the count unchanged
      if (expire && !ref_issue) begin
        if (ref_pending != P_MAX) ref_pending <= ref_pending + 4'd1;
      end else if (!expire && ref_issue) begin
        ref_pending <= ref_pending - 4'd1;
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      ref_cnt    <= '0;
    end else if (state == ISSUE) begin
      if (src_q == SRC_P0  && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (src_q == SRC_P1  && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (src_q == SRC_REF && ref_cnt    != '1) ref_cnt    <= ref_cnt + 16'd1;
    end
  end
`endif

endmodule
